alu_issue_stage: RTL and testbench

Decode-and-issue pipeline register that drives the ALU's operand and operation inputs. Accepts a fetched MIPS instruction plus register-file read data in ID, decodes opcode/funct into the 4-bit ALU operation code, selects and extends operands, and registers everything into the ID/EX boundary. Handles stall (hold), flush (bubble injection) and an issued-instruction counter used by the performance monitor.

---
 rtl/alu_issue_stage.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes a MIPS instruction into ALU operation, operands and control flags,
// with stall/flush handling and a free-running count of issued instructions.
module alu_issue_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  output logic             wr_en,
  output logic [4:0]       wr_reg,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             is_branch,
  output logic             is_jump,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDU = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_SLTI = 4'd12;
  localparam logic [3:0] OP_SLT  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_NONE = 4'd15;

  // instruction fields; the rs index is unused because rs_data arrives already read
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic        unused_rs_field;

  assign opcode          = instr[31:26];
  assign rt_f            = instr[20:16];
  assign rd_f            = instr[15:11];
  assign shamt           = instr[10:6];
  assign funct           = instr[5:0];
  assign imm             = instr[15:0];
  assign imm_sext        = {{16{imm[15]}}, imm};
  assign imm_zext        = {16'b0, imm};
  assign unused_rs_field = ^instr[25:21];

  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_wr_en;
  logic [4:0]  dec_wr_reg;
  logic        dec_mem_rd;
  logic        dec_mem_wr;
  logic        dec_branch;
  logic        dec_jump;
  logic        dec_illegal;

  always_comb begin
    dec_op      = OP_NONE;
    dec_a       = '0;
    dec_b       = '0;
    dec_wr_en   = 1'b0;
    dec_wr_reg  = '0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_branch  = 1'b0;
    dec_jump    = 1'b0;
    dec_illegal = 1'b0;

    case (opcode)
      6'd0: begin
        dec_a      = rs_data;
        dec_b      = rt_data;
        dec_wr_en  = 1'b1;
        dec_wr_reg = rd_f;
        case (funct)
          6'd32:   dec_op = OP_ADD;
          6'd33:   dec_op = OP_ADDU;
          6'd34:   dec_op = OP_SUB;
          6'd35:   dec_op = OP_SUBU;
          6'd36:   dec_op = OP_AND;
          6'd37:   dec_op = OP_OR;
          6'd38:   dec_op = OP_XOR;
          6'd39:   dec_op = OP_NOR;
          6'd42:   dec_op = OP_SLT;
          // the ALU shifts B by A, so the shift amount rides on operand A
          6'd0: begin
            dec_op = OP_SLL;
            dec_a  = {27'b0, shamt};
          end
          6'd2: begin
            dec_op = OP_SRL;
            dec_a  = {27'b0, shamt};
          end
          6'd3: begin
            dec_op = OP_SRA;
            dec_a  = {27'b0, shamt};
          end
          6'd8: begin
            dec_op     = OP_NONE;
            dec_a      = '0;
            dec_b      = '0;
            dec_wr_en  = 1'b0;
            dec_wr_reg = '0;
            dec_jump   = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      6'd28: begin
        if (funct == 6'd2) begin
          dec_op     = OP_MUL;
          dec_a      = rs_data;
          dec_b      = rt_data;
          dec_wr_en  = 1'b1;
          dec_wr_reg = rd_f;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      6'd8, 6'd9, 6'd10: begin
        dec_a      = rs_data;
        dec_b      = imm_sext;
        dec_wr_en  = 1'b1;
        dec_wr_reg = rt_f;
        case (opcode)
          6'd8:    dec_op = OP_ADD;
          6'd9:    dec_op = OP_ADDU;
          default: dec_op = OP_SLTI;
        endcase
      end
      6'd12, 6'd13, 6'd14: begin
        dec_a      = rs_data;
        dec_b      = imm_zext;
        dec_wr_en  = 1'b1;
        dec_wr_reg = rt_f;
        case (opcode)
          6'd12:   dec_op = OP_AND;
          6'd13:   dec_op = OP_OR;
          default: dec_op = OP_XOR;
        endcase
      end
      6'd15: begin
        dec_op     = OP_LUI;
        dec_b      = imm_zext;
        dec_wr_en  = 1'b1;
        dec_wr_reg = rt_f;
      end
      6'd35: begin
        dec_op     = OP_ADD;
        dec_a      = rs_data;
        dec_b      = imm_sext;
        dec_mem_rd = 1'b1;
        dec_wr_en  = 1'b1;
        dec_wr_reg = rt_f;
      end
      6'd43: begin
        dec_op     = OP_ADD;
        dec_a      = rs_data;
        dec_b      = imm_sext;
        dec_mem_wr = 1'b1;
      end
      6'd4, 6'd5: begin
        dec_op     = OP_SUBU;
        dec_a      = rs_data;
        dec_b      = rt_data;
        dec_branch = 1'b1;
      end
      6'd2: dec_jump = 1'b1;
      6'd3: begin
        dec_jump   = 1'b1;
        dec_wr_en  = 1'b1;
        dec_wr_reg = 5'd31;
      end
      default: dec_illegal = 1'b1;
    endcase

    // r0 is hardwired, so a write there is never a real write
    if (dec_wr_reg == 5'd0) begin
      dec_wr_en = 1'b0;
    end

    if (dec_illegal) begin
      dec_op     = OP_NONE;
      dec_a      = '0;
      dec_b      = '0;
      dec_wr_en  = 1'b0;
      dec_wr_reg = '0;
      dec_mem_rd = 1'b0;
      dec_mem_wr = 1'b0;
      dec_branch = 1'b0;
      dec_jump   = 1'b0;
    end
  end

  logic             valid_q,   valid_d;
  logic [31:0]      alu_a_q,   alu_a_d;
  logic [31:0]      alu_b_q,   alu_b_d;
  logic [3:0]       alu_op_q,  alu_op_d;
  logic             wr_en_q,   wr_en_d;
  logic [4:0]       wr_reg_q,  wr_reg_d;
  logic             mem_rd_q,  mem_rd_d;
  logic             mem_wr_q,  mem_wr_d;
  logic             branch_q,  branch_d;
  logic             jump_q,    jump_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // flush beats stall; an idle ID slot also becomes a bubble
  always_comb begin
    valid_d   = valid_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    wr_en_d   = wr_en_q;
    wr_reg_d  = wr_reg_q;
    mem_rd_d  = mem_rd_q;
    mem_wr_d  = mem_wr_q;
    branch_d  = branch_q;
    jump_d    = jump_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;

    if (flush || (!stall && !in_valid)) begin
      valid_d   = 1'b0;
      alu_a_d   = '0;
      alu_b_d   = '0;
      alu_op_d  = OP_NONE;
      wr_en_d   = 1'b0;
      wr_reg_d  = '0;
      mem_rd_d  = 1'b0;
      mem_wr_d  = 1'b0;
      branch_d  = 1'b0;
      jump_d    = 1'b0;
      illegal_d = 1'b0;
    end else if (!stall) begin
      valid_d   = 1'b1;
      alu_a_d   = dec_a;
      alu_b_d   = dec_b;
      alu_op_d  = dec_op;
      wr_en_d   = dec_wr_en;
      wr_reg_d  = dec_wr_reg;
      mem_rd_d  = dec_mem_rd;
      mem_wr_d  = dec_mem_wr;
      branch_d  = dec_branch;
      jump_d    = dec_jump;
      illegal_d = dec_illegal;
      cnt_d     = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= OP_NONE;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      branch_q  <= 1'b0;
      jump_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      branch_q  <= branch_d;
      jump_q    <= jump_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign wr_en      = wr_en_q;
  assign wr_reg     = wr_reg_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign is_branch  = branch_q;
  assign is_jump    = jump_q;
  assign illegal    = illegal_q;
  assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases then randomized traffic,
// compared each cycle against a behavioural decode model (32-bit and 4-bit counter instances).
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  logic [31:0] instr, rs_data, rt_data;

  logic        out_valid, wr_en, mem_rd, mem_wr, is_branch, is_jump, illegal;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  wr_reg;
  logic [31:0] issued_cnt;

  logic        v4, we4, mr4, mw4, br4, jp4, il4;
  logic [31:0] a4, b4;
  logic [3:0]  op4;
  logic [4:0]  wreg4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  alu_issue_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .wr_en(wr_en), .wr_reg(wr_reg), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .is_branch(is_branch), .is_jump(is_jump), .illegal(illegal),
    .issued_cnt(issued_cnt)
  );

  alu_issue_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush),
    .out_valid(v4), .alu_a(a4), .alu_b(b4), .alu_op(op4),
    .wr_en(we4), .wr_reg(wreg4), .mem_rd(mr4), .mem_wr(mw4),
    .is_branch(br4), .is_jump(jp4), .illegal(il4),
    .issued_cnt(cnt4)
  );

  typedef struct {
    logic        valid;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic        mem_rd, mem_wr, br, jmp, ill;
    logic        a_dc, b_dc, reg_dc;   // fields whose value the decode rules leave open
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        m;
  logic [63:0] cnt_m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e.valid = 0; e.a = 0; e.b = 0; e.op = 15; e.wr_en = 0; e.wr_reg = 0;
    e.mem_rd = 0; e.mem_wr = 0; e.br = 0; e.jmp = 0; e.ill = 0;
    e.a_dc = 0; e.b_dc = 0; e.reg_dc = 0;
    return e;
  endfunction

  // Reference decode from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs_v, input logic [31:0] rt_v);
    exp_t        e;
    int          opc, fn;
    logic [31:0] sx, zx;
    e = bubble();
    e.valid = 1;
    opc = int'(ins[31:26]);
    fn  = int'(ins[5:0]);
    sx  = {{16{ins[15]}}, ins[15:0]};
    zx  = {16'h0, ins[15:0]};
    if (opc == 0 && fn >= 32 && fn <= 39) begin
      e.op = 4'(fn - 32); e.a = rs_v; e.b = rt_v; e.wr_en = 1; e.wr_reg = ins[15:11];
    end else if (opc == 0 && fn == 42) begin
      e.op = 13; e.a = rs_v; e.b = rt_v; e.wr_en = 1; e.wr_reg = ins[15:11];
    end else if (opc == 0 && (fn == 0 || fn == 2 || fn == 3)) begin
      e.op = (fn == 0) ? 4'd8 : (fn == 2) ? 4'd9 : 4'd10;
      e.a = 32'(ins[10:6]); e.b = rt_v; e.wr_en = 1; e.wr_reg = ins[15:11];
    end else if (opc == 0 && fn == 8) begin
      e.jmp = 1; e.a_dc = 1; e.b_dc = 1; e.reg_dc = 1;
    end else if (opc == 28 && fn == 2) begin
      e.op = 14; e.a = rs_v; e.b = rt_v; e.wr_en = 1; e.wr_reg = ins[15:11];
    end else if (opc == 8 || opc == 9 || opc == 10) begin
      e.op = (opc == 8) ? 4'd0 : (opc == 9) ? 4'd1 : 4'd12;
      e.a = rs_v; e.b = sx; e.wr_en = 1; e.wr_reg = ins[20:16];
    end else if (opc == 12 || opc == 13 || opc == 14) begin
      e.op = 4'(opc - 8); e.a = rs_v; e.b = zx; e.wr_en = 1; e.wr_reg = ins[20:16];
    end else if (opc == 15) begin
      e.op = 11; e.b = zx; e.a_dc = 1; e.wr_en = 1; e.wr_reg = ins[20:16];
    end else if (opc == 35) begin
      e.op = 0; e.a = rs_v; e.b = sx; e.mem_rd = 1; e.wr_en = 1; e.wr_reg = ins[20:16];
    end else if (opc == 43) begin
      e.op = 0; e.a = rs_v; e.b = sx; e.mem_wr = 1; e.reg_dc = 1;
    end else if (opc == 4 || opc == 5) begin
      e.op = 3; e.a = rs_v; e.b = rt_v; e.br = 1; e.reg_dc = 1;
    end else if (opc == 2) begin
      e.jmp = 1; e.a_dc = 1; e.b_dc = 1; e.reg_dc = 1;
    end else if (opc == 3) begin
      e.jmp = 1; e.wr_en = 1; e.wr_reg = 31; e.a_dc = 1; e.b_dc = 1;
    end else begin
      e.ill = 1; e.reg_dc = 1;
    end
    if (!e.reg_dc && e.wr_reg == 0) e.wr_en = 0;
    return e;
  endfunction

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(m.valid));
    chk("alu_op",    64'(alu_op),    64'(m.op));
    if (!m.a_dc)   chk("alu_a",  64'(alu_a),  64'(m.a));
    if (!m.b_dc)   chk("alu_b",  64'(alu_b),  64'(m.b));
    chk("wr_en",     64'(wr_en),     64'(m.wr_en));
    if (!m.reg_dc) chk("wr_reg", 64'(wr_reg), 64'(m.wr_reg));
    chk("mem_rd",    64'(mem_rd),    64'(m.mem_rd));
    chk("mem_wr",    64'(mem_wr),    64'(m.mem_wr));
    chk("is_branch", 64'(is_branch), 64'(m.br));
    chk("is_jump",   64'(is_jump),   64'(m.jmp));
    chk("illegal",   64'(illegal),   64'(m.ill));
    chk("issued_cnt",   64'(issued_cnt), 64'(cnt_m[31:0]));
    chk("issued_cnt4",  64'(cnt4),       64'(cnt_m[3:0]));
    chk("valid4",    64'(v4),  64'(m.valid));
    chk("alu_op4",   64'(op4), 64'(m.op));
  endtask

  // One clock: update the model with the inputs present at the edge, then compare.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m = bubble(); cnt_m = 0;
    end else if (flush) begin
      m = bubble();
    end else if (!stall) begin
      if (in_valid) begin
        m = ref_decode(instr, rs_data, rt_data);
        cnt_m = cnt_m + 1;
      end else begin
        m = bubble();
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic st, input logic fl);
    in_valid = v; instr = ins; rs_data = a; rt_data = b; stall = st; flush = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] opc_tab [18] = '{0, 0, 0, 2, 3, 4, 5, 8, 9, 10, 12, 13, 14, 15, 28, 35, 43, 63};
    logic [5:0] fn_tab  [15] = '{0, 2, 3, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 1, 40};
    logic [31:0] ins;
    ins = $urandom;
    if ($urandom_range(0, 9) != 0) ins[31:26] = opc_tab[$urandom_range(0, 17)];
    if ($urandom_range(0, 9) != 0) ins[5:0]   = fn_tab[$urandom_range(0, 14)];
    if ($urandom_range(0, 5) == 0) ins[15:11] = 5'd0;
    if ($urandom_range(0, 5) == 0) ins[20:16] = 5'd0;
    return ins;
  endfunction

  initial begin
    m = bubble();
    cnt_m = 0;
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_op",    64'(alu_op),    64'd15);
    chk("rst_cnt",   64'(issued_cnt), 64'd0);
    rst = 0;

    drive(1, 32'h2065FFFC, 32'd10, 32'd0, 0, 0);          // ADDI r5,r3,-4
    step();
    chk("addi_b",   64'(alu_b),  64'hFFFFFFFC);
    chk("addi_reg", 64'(wr_reg), 64'd5);
    chk("addi_cnt", 64'(issued_cnt), 64'd1);

    drive(1, 32'h00071103, 32'd0, 32'h80000000, 0, 0);    // SRA r2,r7,4
    step();
    chk("sra_op", 64'(alu_op), 64'd10);
    chk("sra_a",  64'(alu_a),  64'd4);

    drive(1, 32'h34018000, 32'd0, 32'd0, 0, 0);           // ORI r1,r0,0x8000
    step();
    chk("ori_b", 64'(alu_b), 64'h00008000);

    drive(1, 32'h8C220010, 32'h100, 32'd0, 0, 0);         // LW r2,16(r1)
    step();
    drive(1, 32'hAC220010, 32'h200, 32'd7, 1, 0);         // SW held off by stall
    repeat (3) step();
    chk("stall_mem_rd", 64'(mem_rd), 64'd1);
    chk("stall_cnt",    64'(issued_cnt), 64'd4);
    drive(1, 32'hAC220010, 32'h200, 32'd7, 1, 1);         // stall + flush
    step();
    chk("flush_valid", 64'(out_valid), 64'd0);
    drive(1, 32'hAC220010, 32'h200, 32'd7, 0, 0);
    step();

    drive(1, 32'hFC000000, 32'd5, 32'd6, 0, 0);           // opcode 63
    step();
    chk("ill_flag", 64'(illegal), 64'd1);
    drive(1, 32'h00640021, 32'd1, 32'd2, 0, 0);           // ADDU r0,r3,r4
    step();
    chk("r0_wr_en", 64'(wr_en), 64'd0);
    drive(1, 32'h0C000010, 32'd0, 32'd0, 0, 0);           // JAL
    step();
    chk("jal_reg", 64'(wr_reg), 64'd31);

    drive(1, 32'h2065FFFC, 32'd3, 32'd0, 1, 0);           // reset during stall
    rst = 1;
    step();
    rst = 0;
    drive(1, 32'h2065FFFC, 32'd3, 32'd0, 0, 0);
    step();
    chk("post_rst_cnt", 64'(issued_cnt), 64'd1);

    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 17; i++) begin
      drive(1, rand_instr(), $urandom, $urandom, 0, 0);
      step();
    end
    chk("cnt4_wrap", 64'(cnt4), 64'd1);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 8, rand_instr(), $urandom, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
